// File: rtl/lc3b_types.sv
// Shared LC-3b types for the physical-memory line responder.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  localparam int unsigned PMEM_LINE_BITS = 12;
  localparam int unsigned PMEM_CNT_BITS  = 4;

  typedef logic [PMEM_LINE_BITS-1:0] lc3b_pmem_index;
  typedef logic [PMEM_CNT_BITS-1:0]  lc3b_pmem_count;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } lc3b_pmem_state;

endpackage

// File: rtl/pmem_line_store.sv
// Line array behind the responder: synchronous write, combinational read, no reset.
module pmem_line_store
  import lc3b_types::*;
#(
  parameter int unsigned IndexBits = PMEM_LINE_BITS
) (
  input  logic                 clk,
  input  logic                 write,
  input  logic [IndexBits-1:0] index,
  input  lc3b_line             datain,
  output lc3b_line             dataout
);

  lc3b_line mem_q [1 << IndexBits];

  always_ff @(posedge clk) begin
    if (write) begin
      mem_q[index] <= datain;
    end
  end

  assign dataout = mem_q[index];

endmodule

// File: rtl/pmem_line_responder.sv
// Fixed-latency main-memory stand-in for the two-way cache's 128-bit line port.
module pmem_line_responder
  import lc3b_types::*;
#(
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned LINE_BITS = $bits(lc3b_pmem_index)
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     pmem_read,
  input  logic     pmem_write,
  input  lc3b_word pmem_address,
  input  lc3b_line pmem_wdata,
  output lc3b_line pmem_rdata,
  output logic     pmem_resp,
  output logic     busy,
  output logic     proto_err
);

  localparam lc3b_pmem_count LoadCount = lc3b_pmem_count'(LATENCY - 1);

  lc3b_pmem_state       state_q, state_d;
  lc3b_pmem_count       count_q, count_d;
  logic [LINE_BITS-1:0] idx_q, idx_d;
  lc3b_line             data_q, data_d;
  logic                 we_q, we_d;
  lc3b_line             rdata_q, rdata_d;
  logic                 perr_q, perr_d;

  logic [LINE_BITS-1:0] addr_idx;
  logic [LINE_BITS-1:0] store_idx;
  logic                 store_we;
  lc3b_line             store_dout;
  logic                 load_rd;
  logic                 unused_addr;

  assign addr_idx    = pmem_address[4 +: LINE_BITS];
  assign unused_addr = ^pmem_address[3:0];

  // In IDLE the store is addressed by the live request so a LATENCY=1 read can load rdata
  // on its accepting edge; otherwise the captured index is used.
  assign store_idx = (state_q == IDLE) ? addr_idx : idx_q;
  assign store_we  = (state_q == RESP) && we_q;

  pmem_line_store #(
    .IndexBits(LINE_BITS)
  ) u_store (
    .clk    (clk),
    .write  (store_we),
    .index  (store_idx),
    .datain (data_q),
    .dataout(store_dout)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    data_d  = data_q;
    we_d    = we_q;
    perr_d  = perr_q;
    rdata_d = rdata_q;
    load_rd = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pmem_read || pmem_write) begin
          idx_d   = addr_idx;
          data_d  = pmem_wdata;
          we_d    = pmem_write;
          count_d = LoadCount;
          perr_d  = perr_q | (pmem_read & pmem_write);
          if (LATENCY > 1) begin
            state_d = WAIT;
          end else begin
            state_d = RESP;
            load_rd = ~pmem_write;
          end
        end
      end
      WAIT: begin
        count_d = count_q - 1'b1;
        if (count_q == lc3b_pmem_count'(1)) begin
          state_d = RESP;
          load_rd = ~we_q;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // rdata is registered, so it is loaded on the edge that enters RESP.
    if (load_rd) begin
      rdata_d = store_dout;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      perr_q  <= perr_d;
    end
  end

  assign pmem_rdata = rdata_q;
  assign pmem_resp  = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign proto_err  = perr_q;

endmodule

// File: doc/pmem_line_responder.md
# pmem_line_responder

Physical-memory responder for the LC-3b two-way cache's line interface. It accepts one 128-bit line read or write request from the cache and answers it after a fixed, parameterised latency with a one-cycle `pmem_resp` pulse. It sits between the cache and the bench or top level, standing in for main memory. It holds its own line store, indexed by the line-aligned 16-bit address.

## Interface
- `LATENCY`, default 4: cycles from request acceptance to `pmem_resp`; legal range 1..15.
- `LINE_BITS`, default 12: line-index bits taken from `pmem_address[15:4]`; store depth is 2^LINE_BITS lines.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `pmem_read`  in  1  line read request; held by the cache until `pmem_resp`.
- `pmem_write`  in  1  line write request; held by the cache until `pmem_resp`.
- `pmem_address`  in  16  byte address; bits [3:0] ignored.
- `pmem_wdata`  in  128  write line; word0 = bits [15:0].
- `pmem_rdata`  out  128  read line; valid in the `pmem_resp` cycle of a read.
- `pmem_resp`  out  1  single-cycle completion pulse.
- `busy`  out  1  transaction in flight (state ≠ IDLE).
- `proto_err`  out  1  sticky flag: read and write asserted together when a request was accepted.

## Operation
- Three states: IDLE, WAIT, RESP.
- **IDLE**
  - If `pmem_read | pmem_write`, capture the address line index, `pmem_wdata` and the operation, then load the countdown with `LATENCY-1`.
  - Next state is WAIT if `LATENCY>1`, else RESP.
- **WAIT**: decrement the countdown; go to RESP when it reaches 1.
- **RESP**
  - `pmem_resp`=1 for exactly this cycle.
  - Write: store the captured line at the captured index at the end-of-cycle edge.
  - Read: `pmem_rdata` shows the store contents at the captured index.
  - Next state is always IDLE.
- Request inputs are ignored outside IDLE. Captured values are used even if the cache changes address or data mid-transaction.
- Read and write both high at acceptance: treat as a write, and set `proto_err` until reset.
- Back-to-back requests: after RESP there is always one IDLE cycle. A request still high in that cycle is accepted as a new transaction.
- `pmem_rdata` is registered. It holds its last read value through writes and idle time.
- Addresses wider than the store alias modulo 2^LINE_BITS lines.

## Timing
- Request first high in cycle 0, with the responder in IDLE: `pmem_resp` is high in cycle `LATENCY`, and `busy` is high in cycles 1..`LATENCY`.
- Minimum request-to-request spacing is `LATENCY+1` cycles.
- Write visibility: a read accepted in the IDLE cycle after a write's RESP returns the written line.
- Reset values: state IDLE, countdown 0, `pmem_resp`=0, `busy`=0, `proto_err`=0, `pmem_rdata`=0.
- Reset asserted mid-transaction:
  - The transaction is abandoned and no `pmem_resp` is issued.
  - A pending write is not committed.
  - Store contents are not reset.
- Countdown width is 4 bits and unsigned. It never wraps because it is reloaded only in IDLE.

## Structure
- Add to `lc3b_types`:
  - `lc3b_pmem_state` enum (IDLE, WAIT, RESP).
  - `lc3b_pmem_index` typedef, width `LINE_BITS` default.
  - Reuse `lc3b_word` and `lc3b_line`.
- One sub-module, `pmem_line_store`: a synchronous-write, combinational-read array of `lc3b_line`, with no reset. Ports: clk, write, index, datain, dataout.
- The FSM, countdown, capture registers and `pmem_rdata` register live in the top module.

## Test plan
- Reset then idle: hold `reset_n`=0 for 3 cycles, release with no requests → `pmem_resp`, `busy`, `proto_err` and `pmem_rdata` stay 0 for 20 cycles.
- Write then read, `LATENCY`=4:
  - Write 0x0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 to address 0x1230 → `pmem_resp` is high in cycle 4 only.
  - Read 0x123A, accepted in the following IDLE cycle → `pmem_rdata` equals that line in its resp cycle.
- Latency sweep: `LATENCY`=1 and 15 → resp lands exactly in cycle 1 and cycle 15 after request; `busy` width matches.
- Address/data changed mid-transaction: change `pmem_address` to 0x4000 in cycle 2 of a write to 0x0010 → line 0x0010 updated, 0x4000 unchanged.
- Simultaneous request: read and write both high to 0x0020 → handled as a write, `proto_err` rises the cycle after acceptance and stays 1.
- Reset mid-write: assert `reset_n`=0 in cycle 2 of a write to 0x0040 → no `pmem_resp`, and a subsequent read of 0x0040 returns the old contents.
